dmem_ram_ctrl: RTL and testbench

DMEM_RAM_CTRL -- requirements
Module: dmem_ram_ctrl

---
 rtl/dmem_pkg.sv | 68 ++++++
 rtl/dmem_load_align.sv | 54 +++++
 rtl/dmem_ram_ctrl.sv | 152 +++++++++++++++
 tb/tb_dmem_ram_ctrl.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// ---------------------------------------------------------------------------
// dmem_pkg
//
// Shared definitions for the data-memory RAM controller:
//   size_e   - access size encoding carried on req_size
//   state_e  - controller FSM state encoding
//   isMisaligned / storeMask / storeData - small helpers used in the request
//              (acceptance) path of the controller
// ---------------------------------------------------------------------------
package dmem_pkg;

  // Access size as presented by the CPU; SZ_RSVD is never a legal access.
  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_RSVD = 2'd3
  } size_e;

  // Controller states: idle/accepting, waiting one cycle for RAM read data,
  // and presenting a response until the CPU takes it.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RSP     = 2'd2
  } state_e;

  // An access is bad when its size is reserved or when the byte address is
  // not a multiple of the access size.
  function automatic logic isMisaligned(input size_e size, input logic [1:0] addrLow);
    logic bad;
    bad = 1'b0;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = addrLow[0];
      SZ_WORD: bad = (addrLow != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Per-byte write enables for an aligned store at the given word offset.
  function automatic logic [3:0] storeMask(input size_e size, input logic [1:0] addrLow);
    logic [3:0] mask;
    mask = 4'b0000;
    case (size)
      SZ_BYTE: mask = 4'b0001 << addrLow;
      SZ_HALF: mask = addrLow[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: mask = 4'b1111;
      default: mask = 4'b0000;
    endcase
    return mask;
  endfunction

  // Store data replicated across every lane, so whichever lanes the write
  // enables select already carry the right bytes.
  function automatic logic [31:0] storeData(input size_e size, input logic [31:0] wdata);
    logic [31:0] data;
    data = wdata;
    case (size)
      SZ_BYTE: data = {4{wdata[7:0]}};
      SZ_HALF: data = {2{wdata[15:0]}};
      default: data = wdata;
    endcase
    return data;
  endfunction

endpackage

// File: rtl/dmem_load_align.sv
// ---------------------------------------------------------------------------
// dmem_load_align
//
// Purely combinational load formatter: picks the addressed byte or halfword
// lane out of a 32-bit RAM word and sign- or zero-extends it to 32 bits.
// Word loads pass straight through.
//
// Ports:
//   rdata_i    in  32  raw RAM read word
//   byteOff_i  in   2  byte offset of the access inside the word
//   size_i     in   2  access size (size_e)
//   zeroExt_i  in   1  1 = zero-extend, 0 = sign-extend
//   data_o     out 32  right-aligned, extended load data
// ---------------------------------------------------------------------------
module dmem_load_align
  import dmem_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  byteOff_i,
  input  size_e       size_i,
  input  logic        zeroExt_i,
  output logic [31:0] data_o
);

  logic [7:0]  byteLane;
  logic [15:0] halfLane;

  // Lane selection: the byte offset picks one of four bytes, its upper bit
  // picks one of two halfwords (the low bit is zero for legal halves).
  always_comb begin
    byteLane = rdata_i[7:0];
    case (byteOff_i)
      2'd0: byteLane = rdata_i[7:0];
      2'd1: byteLane = rdata_i[15:8];
      2'd2: byteLane = rdata_i[23:16];
      2'd3: byteLane = rdata_i[31:24];
      default: byteLane = rdata_i[7:0];
    endcase
    halfLane = byteOff_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  end

  // Extension to a full word according to size and signedness.
  always_comb begin
    data_o = rdata_i;
    case (size_i)
      SZ_BYTE: data_o = zeroExt_i ? {24'h000000, byteLane}
                                  : {{24{byteLane[7]}}, byteLane};
      SZ_HALF: data_o = zeroExt_i ? {16'h0000, halfLane}
                                  : {{16{halfLane[15]}}, halfLane};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/dmem_ram_ctrl.sv
// ---------------------------------------------------------------------------
// dmem_ram_ctrl
//
// Bridges a valid/ready CPU data port onto a single-port byte-write RAM with
// one cycle of read latency. One request is in flight at a time:
//   store      : RAM written in the acceptance cycle, response next cycle
//   load       : RAM addressed in the acceptance cycle, data formatted the
//                following cycle, response two cycles after acceptance
//   bad access : no RAM write, error response next cycle
// The response is held until the CPU takes it; only then is a new request
// accepted.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   req_valid / req_ready  request handshake (ready only while idle)
//   req_addr               byte address (ADDR_WIDTH+2 bits)
//   req_write              1 = store, 0 = load
//   req_size               0 byte, 1 half, 2 word, 3 reserved
//   req_unsigned           load extension: 1 zero, 0 sign
//   req_wdata              right-aligned store data
//   rsp_valid / rsp_ready  response handshake
//   rsp_rdata              extended load data, 0 for stores and errors
//   rsp_err                misaligned or reserved-size access
//   ram_addr               RAM word address
//   ram_we                 per-byte write enables
//   ram_din                RAM write data (replicated store data)
//   ram_dout               RAM read data, valid the cycle after addressing
// ---------------------------------------------------------------------------
module dmem_ram_ctrl
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH+1:0] req_addr,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [3:0]            ram_we,
  output logic [31:0]           ram_din,
  input  logic [31:0]           ram_dout
);

  state_e      state_q;
  logic        rspValid_q;
  logic        rspErr_q;
  logic [31:0] rspRdata_q;

  // Request attributes kept for formatting the read data one cycle later.
  logic [1:0]  addrLow_q;
  size_e       size_q;
  logic        zeroExt_q;

  size_e       reqSize;
  logic        accept;
  logic        misaligned;
  logic [31:0] loadData_d;

  assign reqSize    = size_e'(req_size);
  assign misaligned = isMisaligned(reqSize, req_addr[1:0]);

  // Ready is gated by reset directly so no request can slip in while the
  // state register is being cleared.
  assign req_ready = (state_q == IDLE) && !rst;
  assign accept    = req_valid && req_ready;

  // The RAM sees the request address and data straight away; only the write
  // enables decide whether anything actually happens.
  assign ram_addr = req_addr[ADDR_WIDTH+1:2];
  assign ram_din  = storeData(reqSize, req_wdata);
  assign ram_we   = (accept && req_write && !misaligned)
                  ? storeMask(reqSize, req_addr[1:0]) : 4'b0000;

  assign rsp_valid = rspValid_q;
  assign rsp_rdata = rspRdata_q;
  assign rsp_err   = rspErr_q;

  dmem_load_align u_load_align (
    .rdata_i   (ram_dout),
    .byteOff_i (addrLow_q),
    .size_i    (size_q),
    .zeroExt_i (zeroExt_q),
    .data_o    (loadData_d)
  );

  // Controller FSM with registered response outputs. A reset anywhere drops
  // the in-flight access and its response is never presented.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rspValid_q <= 1'b0;
      rspErr_q   <= 1'b0;
      rspRdata_q <= 32'h0000_0000;
      addrLow_q  <= 2'b00;
      size_q     <= SZ_BYTE;
      zeroExt_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            addrLow_q <= req_addr[1:0];
            size_q    <= reqSize;
            zeroExt_q <= req_unsigned;
            if (misaligned) begin
              state_q    <= RSP;
              rspValid_q <= 1'b1;
              rspErr_q   <= 1'b1;
              rspRdata_q <= 32'h0000_0000;
            end else if (req_write) begin
              state_q    <= RSP;
              rspValid_q <= 1'b1;
              rspErr_q   <= 1'b0;
              rspRdata_q <= 32'h0000_0000;
            end else begin
              state_q <= RD_WAIT;
            end
          end
        end
        RD_WAIT: begin
          state_q    <= RSP;
          rspValid_q <= 1'b1;
          rspErr_q   <= 1'b0;
          rspRdata_q <= loadData_d;
        end
        RSP: begin
          if (rsp_ready) begin
            state_q    <= IDLE;
            rspValid_q <= 1'b0;
            rspErr_q   <= 1'b0;
            rspRdata_q <= 32'h0000_0000;
          end
        end
        default: begin
          state_q    <= IDLE;
          rspValid_q <= 1'b0;
          rspErr_q   <= 1'b0;
          rspRdata_q <= 32'h0000_0000;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_ram_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dmem_ram_ctrl
//
// Drives directed CPU requests into dmem_ram_ctrl attached to a behavioural
// byte-write RAM. A transaction-level model (byte-addressed memory plus a
// latency counter) predicts every cycle's handshake, write-enable and
// response values; directed literal expectations pin the model itself.
// ---------------------------------------------------------------------------
module tb_dmem_ram_ctrl;
  import dmem_pkg::*;

  localparam int AW = 12;
  localparam int NBYTES = 1 << (AW + 2);

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [AW+1:0] req_addr;
  logic          req_write;
  logic [1:0]    req_size;
  logic          req_unsigned;
  logic [31:0]   req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;
  logic [AW-1:0] ram_addr;
  logic [3:0]    ram_we;
  logic [31:0]   ram_din;
  logic [31:0]   ram_dout;

  int checks = 0;
  int failures = 0;

  // Values seen by the request task in the acceptance cycle.
  logic [3:0]    accWe;
  logic [31:0]   accDin;
  logic [AW-1:0] accAddr;

  always #5 clk = ~clk;

  dmem_ram_ctrl #(.ADDR_WIDTH(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr     (req_addr),
    .req_write    (req_write),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .ram_addr     (ram_addr),
    .ram_we       (ram_we),
    .ram_din      (ram_din),
    .ram_dout     (ram_dout)
  );

  // Behavioural byte-write RAM with one cycle of read latency.
  logic [31:0] ramMem [0:(1<<AW)-1];
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (ram_we[b]) ramMem[ram_addr][8*b +: 8] <= ram_din[8*b +: 8];
    ram_dout <= ramMem[ram_addr];
  end

  // Reference memory used only by the model.
  logic [7:0] refMem [0:NBYTES-1];

  initial begin
    for (int i = 0; i < (1 << AW); i++) ramMem[i] = 32'h0;
    for (int i = 0; i < NBYTES; i++) refMem[i] = 8'h00;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic reportTimeout(input string name);
    checks++;
    failures++;
    $display("[TB] FAIL %s actual=timeout required=handshake at %0t", name, $time);
  endtask

  function automatic logic modelMisaligned(input logic [1:0] sz, input logic [AW+1:0] a);
    int addr;
    addr = int'(a);
    if (sz == 2'd3) return 1'b1;
    if (sz == 2'd1 && (addr % 2) != 0) return 1'b1;
    if (sz == 2'd2 && (addr % 4) != 0) return 1'b1;
    return 1'b0;
  endfunction

  // Model state: one outstanding access, cycles left before its response
  // appears, and the response contents.
  logic        mPending = 1'b0;
  int          mCount = 0;
  logic [31:0] mData = 32'h0;
  logic        mErr = 1'b0;
  logic        mLastRst = 1'b0;

  // Compare process: check at every falling edge, then advance the model at
  // the following rising edge with the inputs seen at the falling edge.
  initial begin : modelCompare
    logic        expReady, acc, mis, presenting;
    logic        sRst, sWrite, sUns, sRspReady;
    logic [1:0]  sSize;
    logic [AW+1:0] sAddr;
    logic [31:0] sWdata, expDin, val;
    logic [3:0]  expWe;
    int          nBytes, base;
    forever begin
      @(negedge clk);
      sRst = rst; sWrite = req_write; sUns = req_unsigned; sRspReady = rsp_ready;
      sSize = req_size; sAddr = req_addr; sWdata = req_wdata;
      expReady   = !sRst && !mPending;
      acc        = req_valid && expReady;
      mis        = modelMisaligned(sSize, sAddr);
      nBytes     = 1 << sSize;
      presenting = mPending && (mCount == 0);
      expWe = 4'b0000;
      if (acc && sWrite && !mis)
        for (int i = 0; i < nBytes; i++) expWe[int'(sAddr[1:0]) + i] = 1'b1;
      for (int k = 0; k < 4; k++) expDin[8*k +: 8] = sWdata[8*(k % nBytes) +: 8];

      checkOutput("req_ready", 32'(req_ready), 32'(expReady));
      checkOutput("rsp_valid", 32'(rsp_valid), 32'(presenting));
      if (presenting) begin
        checkOutput("rsp_rdata", rsp_rdata, mData);
        checkOutput("rsp_err", 32'(rsp_err), 32'(mErr));
      end
      if (mLastRst) begin
        checkOutput("rst_rdata", rsp_rdata, 32'h0);
        checkOutput("rst_err", 32'(rsp_err), 32'h0);
      end
      checkOutput("ram_we", 32'(ram_we), 32'(expWe));
      if (expWe != 4'b0000) checkOutput("ram_din", ram_din, expDin);
      if (acc) checkOutput("ram_addr", 32'(ram_addr), 32'(sAddr) >> 2);

      @(posedge clk);
      mLastRst = sRst;
      if (sRst) begin
        mPending = 1'b0;
        mCount   = 0;
      end else if (mPending) begin
        if (presenting && sRspReady) mPending = 1'b0;
        else if (mCount > 0) mCount--;
      end else if (acc) begin
        base = int'(sAddr);
        mPending = 1'b1;
        if (mis) begin
          mData = 32'h0; mErr = 1'b1; mCount = 0;
        end else if (sWrite) begin
          for (int i = 0; i < nBytes; i++) refMem[base + i] = sWdata[8*i +: 8];
          mData = 32'h0; mErr = 1'b0; mCount = 0;
        end else begin
          val = 32'h0;
          for (int i = 0; i < nBytes; i++) val = val | (32'(refMem[base + i]) << (8*i));
          if (!sUns && nBytes < 4 && val[8*nBytes-1])
            for (int j = 8*nBytes; j < 32; j++) val[j] = 1'b1;
          mData = val; mErr = 1'b0; mCount = 1;
        end
      end
    end
  end

  // Present one request and wait (bounded) for it to be accepted. Entered
  // and left just after a rising edge.
  task automatic applyStimulus(input logic wr, input logic [1:0] sz, input logic uns,
                               input logic [AW+1:0] addr, input logic [31:0] wd,
                               output int waitCycles);
    bit accepted;
    accepted = 0;
    waitCycles = 0;
    req_valid = 1'b1; req_write = wr; req_size = sz;
    req_unsigned = uns; req_addr = addr; req_wdata = wd;
    for (int i = 0; i < 20 && !accepted; i++) begin
      @(negedge clk);
      if (req_ready) begin
        accepted = 1;
        accWe = ram_we; accDin = ram_din; accAddr = ram_addr;
      end else begin
        waitCycles++;
      end
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    if (!accepted) reportTimeout("accept_timeout");
  endtask

  // Wait (bounded) for the response, optionally stall it, then take it.
  task automatic waitResponse(input int holdCycles, output logic [31:0] data,
                              output logic err, output int latency);
    bit seen;
    seen = 0; latency = 0; data = 32'h0; err = 1'b0;
    if (holdCycles == 0) rsp_ready = 1'b1;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      latency++;
      if (rsp_valid) seen = 1;
    end
    if (!seen) begin
      reportTimeout("rsp_timeout");
      rsp_ready = 1'b0;
      @(posedge clk);
      #1;
      return;
    end
    data = rsp_rdata;
    err  = rsp_err;
    if (holdCycles > 0) begin
      repeat (holdCycles) begin
        @(posedge clk);
        #1;
      end
      checkOutput("hold_valid", 32'(rsp_valid), 32'd1);
      checkOutput("hold_req_ready", 32'(req_ready), 32'd0);
      rsp_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    logic [31:0] data;
    logic        err;
    int          lat, waitC, validCount;

    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = 32'h0; rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_ready", 32'(req_ready), 32'd1);
    checkOutput("reset_valid", 32'(rsp_valid), 32'd0);
    @(posedge clk);
    #1;

    $display("[TB] store byte 0x005");
    applyStimulus(1'b1, SZ_BYTE, 1'b0, 14'h005, 32'h0000_00AB, waitC);
    checkOutput("sb_we", 32'(accWe), 32'h2);
    checkOutput("sb_din", accDin, 32'hABAB_ABAB);
    checkOutput("sb_addr", 32'(accAddr), 32'd1);
    waitResponse(0, data, err, lat);
    checkOutput("sb_lat", 32'(lat), 32'd1);
    checkOutput("sb_err", 32'(err), 32'd0);
    checkOutput("sb_rdata", data, 32'h0);

    $display("[TB] store word 0x004");
    applyStimulus(1'b1, SZ_WORD, 1'b0, 14'h004, 32'h80F0_1234, waitC);
    checkOutput("sw_we", 32'(accWe), 32'hF);
    checkOutput("sw_din", accDin, 32'h80F0_1234);
    waitResponse(0, data, err, lat);

    $display("[TB] load half 0x006 signed / unsigned");
    applyStimulus(1'b0, SZ_HALF, 1'b0, 14'h006, 32'h0, waitC);
    checkOutput("lh_we", 32'(accWe), 32'h0);
    waitResponse(0, data, err, lat);
    checkOutput("lh_rdata", data, 32'hFFFF_80F0);
    checkOutput("lh_lat", 32'(lat), 32'd2);
    applyStimulus(1'b0, SZ_HALF, 1'b1, 14'h006, 32'h0, waitC);
    waitResponse(0, data, err, lat);
    checkOutput("lhu_rdata", data, 32'h0000_80F0);
    checkOutput("lhu_lat", 32'(lat), 32'd2);

    $display("[TB] misaligned load word 0x002");
    applyStimulus(1'b0, SZ_WORD, 1'b0, 14'h002, 32'h0, waitC);
    checkOutput("mis_we", 32'(accWe), 32'h0);
    waitResponse(0, data, err, lat);
    checkOutput("mis_err", 32'(err), 32'd1);
    checkOutput("mis_rdata", data, 32'h0);
    checkOutput("mis_lat", 32'(lat), 32'd1);

    $display("[TB] stalled response, load byte 0x007");
    applyStimulus(1'b0, SZ_BYTE, 1'b0, 14'h007, 32'h0, waitC);
    waitResponse(5, data, err, lat);
    checkOutput("lb_rdata", data, 32'hFFFF_FF80);
    checkOutput("lb_lat", 32'(lat), 32'd2);
    applyStimulus(1'b0, SZ_BYTE, 1'b1, 14'h004, 32'h0, waitC);
    checkOutput("next_accept_wait", 32'(waitC), 32'd0);
    waitResponse(0, data, err, lat);
    checkOutput("lbu_rdata", data, 32'h0000_0034);

    $display("[TB] store half 0x00A, load word 0x008");
    applyStimulus(1'b1, SZ_HALF, 1'b0, 14'h00A, 32'h0000_BEEF, waitC);
    checkOutput("sh_we", 32'(accWe), 32'hC);
    checkOutput("sh_din", accDin, 32'hBEEF_BEEF);
    waitResponse(0, data, err, lat);
    applyStimulus(1'b0, SZ_WORD, 1'b0, 14'h008, 32'h0, waitC);
    waitResponse(0, data, err, lat);
    checkOutput("lw8_rdata", data, 32'hBEEF_0000);

    $display("[TB] reserved size and misaligned half store");
    applyStimulus(1'b1, SZ_RSVD, 1'b0, 14'h000, 32'hDEAD_BEEF, waitC);
    checkOutput("rsvd_we", 32'(accWe), 32'h0);
    waitResponse(0, data, err, lat);
    checkOutput("rsvd_err", 32'(err), 32'd1);
    applyStimulus(1'b1, SZ_HALF, 1'b0, 14'h001, 32'h0000_5555, waitC);
    checkOutput("mish_we", 32'(accWe), 32'h0);
    waitResponse(0, data, err, lat);
    checkOutput("mish_err", 32'(err), 32'd1);

    $display("[TB] reset during read wait");
    applyStimulus(1'b0, SZ_WORD, 1'b0, 14'h004, 32'h0, waitC);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_ready", 32'(req_ready), 32'd1);
    validCount = 0;
    for (int i = 0; i < 5; i++) begin
      if (rsp_valid) validCount++;
      @(negedge clk);
    end
    checkOutput("discarded_rsp", 32'(validCount), 32'd0);
    @(posedge clk);
    #1;

    $display("[TB] back-to-back store/load word 0x010");
    applyStimulus(1'b1, SZ_WORD, 1'b0, 14'h010, 32'h1122_3344, waitC);
    checkOutput("sw10_addr", 32'(accAddr), 32'd4);
    waitResponse(0, data, err, lat);
    applyStimulus(1'b0, SZ_WORD, 1'b0, 14'h010, 32'h0, waitC);
    waitResponse(0, data, err, lat);
    checkOutput("lw10_rdata", data, 32'h1122_3344);
    checkOutput("lw10_err", 32'(err), 32'd0);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
